// File: rtl/data_memory_if.sv
// rtl/data_memory_if.sv - MEM-stage load/store bus between the core and data_memory
interface data_memory_if;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        stall;
  logic        valid;
  logic        misalign;

  modport master (
    output memread, memwrite, addr, writedata,
    input  readdata, stall, valid, misalign
  );

  modport slave (
    input  memread, memwrite, addr, writedata,
    output readdata, stall, valid, misalign
  );
endinterface

// File: rtl/data_memory.sv
// rtl/data_memory.sv - word-organized data memory with fixed access latency and pipeline stall
module data_memory #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst,
  data_memory_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [31:0]   readdata_q;
  logic          valid_q;
  logic          misalign_q;
  logic          mis_pend_q;
  logic [31:0]   mem [DEPTH];

  logic          req;
  logic          mis;
  logic          capture;
  logic [AW-1:0] widx;
  logic          unused_addr;

  assign req         = bus.memread | bus.memwrite;
  assign mis         = |bus.addr[1:0];
  assign widx        = bus.addr[AW+1:2];
  assign capture     = (state_q == IDLE) && req;
  assign unused_addr = ^bus.addr[31:AW+2];

  // Stall must rise in the request cycle itself, so it cannot be registered.
  assign bus.stall    = !rst && (capture || (state_q == BUSY));
  assign bus.valid    = valid_q;
  assign bus.misalign = misalign_q;
  assign bus.readdata = readdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      readdata_q <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      mis_pend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q    <= 1'b0;
          misalign_q <= 1'b0;
          if (req) begin
            mis_pend_q <= mis;
            // A combined read+write strobe is a store and leaves readdata alone.
            if (bus.memread && !bus.memwrite) begin
              readdata_q <= mis ? 32'd0 : mem[widx];
            end
            if (LATENCY == 1) begin
              state_q    <= DONE;
              valid_q    <= 1'b1;
              misalign_q <= mis;
            end else begin
              state_q <= BUSY;
              cnt_q   <= 4'(LATENCY - 2);
            end
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q    <= DONE;
            valid_q    <= 1'b1;
            misalign_q <= mis_pend_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          // Strobes are still up for the same instruction; never re-capture here.
          state_q    <= IDLE;
          valid_q    <= 1'b0;
          misalign_q <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          valid_q    <= 1'b0;
          misalign_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && capture && bus.memwrite && !mis) begin
      mem[widx] <= bus.writedata;
    end
  end
endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - scoreboard bench for data_memory across LATENCY 1..4
module tb_data_memory;
  logic clk = 1'b0;
  logic rst;

  logic [3:0]        memread_a;
  logic [3:0]        memwrite_a;
  logic [3:0][31:0]  addr_a;
  logic [3:0][31:0]  wdata_a;
  logic [3:0][31:0]  readdata_a;
  logic [3:0]        stall_a;
  logic [3:0]        valid_a;
  logic [3:0]        misalign_a;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [4][256];
  logic [31:0] rd_m  [4];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  // DUT index g runs with LATENCY g+1
  for (genvar g = 0; g < 4; g++) begin : g_dut
    data_memory_if bus();
    assign bus.memread   = memread_a[g];
    assign bus.memwrite  = memwrite_a[g];
    assign bus.addr      = addr_a[g];
    assign bus.writedata = wdata_a[g];
    assign readdata_a[g] = bus.readdata;
    assign stall_a[g]    = bus.stall;
    assign valid_a[g]    = bus.valid;
    assign misalign_a[g] = bus.misalign;
    data_memory #(.DEPTH(256), .LATENCY(g + 1)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at posedge+1; leaves strobes asserted and returns at posedge+1 after valid.
  task automatic do_req(input int d, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd);
    int   lat = d + 1;
    bit   found = 0;
    exp_t e;
    logic m = (a[1:0] != 2'b00);
    if (wr) begin
      if (!m) mem_m[d][a[9:2]] = wd;
    end else if (rd) begin
      rd_m[d] = m ? 32'd0 : mem_m[d][a[9:2]];
    end
    e.rd  = rd_m[d];
    e.mis = m;
    sb.push_back(e);
    memread_a[d]  = rd;
    memwrite_a[d] = wr;
    addr_a[d]     = a;
    wdata_a[d]    = wd;
    for (int c = 0; c <= lat + 2 && !found; c++) begin
      @(negedge clk);
      if (valid_a[d]) begin
        check("valid_cycle", 32'(c), 32'(lat));
        check("stall_done", 32'(stall_a[d]), 32'd0);
        e = sb.pop_front();
        check("readdata", readdata_a[d], e.rd);
        check("misalign", 32'(misalign_a[d]), 32'(e.mis));
        found = 1;
      end else begin
        check("stall_busy", 32'(stall_a[d]), 32'd1);
        check("misalign_idle", 32'(misalign_a[d]), 32'd0);
      end
      @(posedge clk); #1;
    end
    check("valid_seen", 32'(found), 32'd1);
  endtask

  task automatic idle(input int d);
    memread_a[d]  = 1'b0;
    memwrite_a[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    rst        = 1'b1;
    memread_a  = '1;
    memwrite_a = '0;
    addr_a     = '0;
    wdata_a    = '0;
    for (int i = 0; i < 4; i++) rd_m[i] = 32'd0;
    #2;
    for (int i = 0; i < 4; i++) begin
      check("rst_stall", 32'(stall_a[i]), 32'd0);
      check("rst_valid", 32'(valid_a[i]), 32'd0);
      check("rst_readdata", readdata_a[i], 32'd0);
      check("rst_misalign", 32'(misalign_a[i]), 32'd0);
    end
    memread_a = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // LATENCY=2: store/load, misaligned accesses, combined strobes
    do_req(1, 0, 1, 32'h40, 32'hDEADBEEF);
    do_req(1, 1, 0, 32'h40, 32'h0);
    do_req(1, 1, 0, 32'h41, 32'h0);
    do_req(1, 1, 0, 32'h40, 32'h0);
    do_req(1, 0, 1, 32'h42, 32'h0BADF00D);
    do_req(1, 1, 0, 32'h40, 32'h0);
    do_req(1, 1, 1, 32'h80, 32'hA5A5A5A5);
    do_req(1, 1, 0, 32'h80, 32'h0);
    idle(1);

    // LATENCY=1: address wrap aliasing
    do_req(0, 0, 1, 32'h0, 32'h12345678);
    do_req(0, 1, 0, 32'h400, 32'h0);
    do_req(0, 1, 0, 32'hFFFF_FC00, 32'h0);
    idle(0);

    // LATENCY=3: strobes held continuously give one completion per 4 cycles
    do_req(2, 0, 1, 32'h8, 32'h55AA55AA);
    rd_m[2] = mem_m[2][2];
    e.rd  = rd_m[2];
    e.mis = 1'b0;
    sb.push_back(e);
    sb.push_back(e);
    memread_a[2]  = 1'b1;
    memwrite_a[2] = 1'b0;
    addr_a[2]     = 32'h8;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("held_valid", 32'(valid_a[2]), 32'(c == 3 || c == 7));
      check("held_stall", 32'(stall_a[2]), 32'(!(c == 3 || c == 7)));
      if (valid_a[2] && sb.size() > 0) begin
        e = sb.pop_front();
        check("held_readdata", readdata_a[2], e.rd);
      end
      @(posedge clk); #1;
    end
    idle(2);

    // LATENCY=4: asynchronous reset during the BUSY phase of a store
    do_req(3, 0, 1, 32'h20, 32'h00000011);
    do_req(3, 1, 0, 32'h20, 32'h0);
    memread_a[3]  = 1'b0;
    memwrite_a[3] = 1'b1;
    addr_a[3]     = 32'h10;
    wdata_a[3]    = 32'hCAFEF00D;
    @(posedge clk); #3;
    check("pre_rst_stall", 32'(stall_a[3]), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_stall", 32'(stall_a[3]), 32'd0);
    check("arst_valid", 32'(valid_a[3]), 32'd0);
    check("arst_readdata", readdata_a[3], 32'd0);
    check("arst_misalign", 32'(misalign_a[3]), 32'd0);
    @(posedge clk); #1;
    check("arst_stall_held", 32'(stall_a[3]), 32'd0);
    rst           = 1'b0;
    memwrite_a[3] = 1'b0;
    mem_m[3][4]   = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) rd_m[i] = 32'd0;
    @(posedge clk); #1;
    do_req(3, 1, 0, 32'h10, 32'h0);
    idle(3);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_memory.md
# data_memory

Word-organized data memory responder for the MIPS core: the target end of the `memread`/`memwrite` strobes produced by instruction decode. It captures one load or store per request, models a fixed access latency, and holds the pipeline with `stall` until the access completes. It then returns load data with a one-cycle `valid` pulse. It sits in the MEM stage between the ALU result and the write-back mux selected by `memtoreg`.

## Interface
Parameters:
- `DEPTH`, 256: number of 32-bit words; a power of two, 4..65536.
- `LATENCY`, 2: total stall cycles per access; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `memread`  in  1  load request.
- `memwrite`  in  1  store request.
- `addr`  in  32  byte address (ALU result).
- `writedata`  in  32  store data.
- `readdata`  out  32  load data; registered.
- `stall`  out  1  pipeline hold request.
- `valid`  out  1  one-cycle completion pulse.
- `misalign`  out  1  completed request had `addr[1:0]` != 0; qualified by `valid`.

## Operation
- States: IDLE, BUSY, DONE. Reset state is IDLE.
- Request: `req = memread | memwrite`.
- IDLE with `req` = 1:
  - `stall` = 1 combinationally in the same cycle.
  - At the edge, capture the request.
  - `LATENCY` = 1: go to DONE.
  - `LATENCY` >= 2: go to BUSY with the down-counter loaded to `LATENCY`-2.
- IDLE with `req` = 0: stay in IDLE; `stall` = 0.
- BUSY:
  - `stall` = 1.
  - Inputs are ignored; the pipeline holds them stable.
  - Counter = 0: go to DONE. Otherwise decrement.
- DONE:
  - `stall` = 0, `valid` = 1.
  - Go to IDLE unconditionally. The request strobes, still asserted by the same instruction, are ignored, so the same instruction never issues twice.
- Word index is `addr[log2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses wrap modulo `DEPTH`*4.
- Capture-edge actions:
  - Store, aligned: the array word is written at the capture edge. The write is fully committed there; `readdata` is unchanged.
  - Load, aligned: `readdata` <= array word at the capture edge.
  - Misaligned (`addr[1:0]` != 0): no array write. A load sets `readdata` <= 0; a store leaves `readdata` unchanged. The `misalign` flag is registered and presented in DONE.
  - `memread` and `memwrite` both 1: treated as a store; `readdata` unchanged.
- `readdata` holds its last value until the next load capture.
- `misalign` is 1 only in DONE for a misaligned request; 0 in all other states.
- The array is not cleared by reset. Its contents are undefined until written.

## Timing
- Reset values: state IDLE, counter 0, `readdata` 0, `valid` 0, `misalign` 0. `stall` is forced to 0 while `rst` = 1, regardless of the request inputs.
- With the request first presented in cycle 0:
  - `stall` = 1 in cycles 0..`LATENCY`-1.
  - Cycle `LATENCY`: `valid` = 1 and `readdata` is final.
  - The pipeline advances at the end of cycle `LATENCY`.
- Back-to-back: a new request may be presented in cycle `LATENCY`+1 (IDLE). Minimum spacing is `LATENCY`+1 cycles.
- Reset asserted in BUSY or DONE: immediate return to IDLE with all outputs at reset values. A store captured before reset remains in the array; no partial writes are possible.
- `LATENCY` = 1: no BUSY cycle. The sequence is IDLE(stall) -> DONE(valid) -> IDLE.

## Test plan
- Store then load, `LATENCY`=2:
  - Store 0xDEADBEEF to 0x40: `stall` = 1 for 2 cycles, `valid` in cycle 2.
  - Then load 0x40: `readdata` = 0xDEADBEEF with `valid` in cycle 2; `misalign` = 0 throughout.
- `LATENCY`=1, `DEPTH`=256:
  - Load 0x400 aliases word 0.
  - After storing 0x12345678 at 0x0, load 0x400 returns 0x12345678 one cycle after request; `stall` is high for exactly 1 cycle.
- Misaligned load at 0x41 after `readdata` = 0xDEADBEEF:
  - In DONE, `misalign` = 1, `valid` = 1, `readdata` = 0.
  - A subsequent aligned load of 0x40 still returns the stored value. A misaligned store to 0x42 leaves word 0x40 unchanged.
- Strobes held high through DONE, `LATENCY`=3:
  - Exactly one `valid` pulse per request; no re-capture.
  - A new request held from cycle 4 completes with `valid` in cycle 7.
- Simultaneous `memread` = `memwrite` = 1, `writedata` 0xA5A5A5A5 at 0x80:
  - The word is written; `readdata` is unchanged.
  - A following load of 0x80 returns 0xA5A5A5A5.
- Async reset in the BUSY cycle of a store with `LATENCY`=4:
  - Outputs drop to reset values immediately; `stall` = 0 while `rst` = 1.
  - After release, a load of that address returns the stored data.
